// File: rtl/sort_pkg.sv
// sort_pkg
// Shared types and helpers for the insertion_sort_p buffer.
//   state_t      : sort FSM states (IDLE, FETCH, CMP, DONE)
//   out_of_order : strict ordering test used by the compare step
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    CMP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Widest operand the compare helper handles.
  localparam int MAX_W = 64;

  // Returns 1 when a must move behind key b.
  // Operands arrive zero-extended from width w. For a signed compare the
  // sign bit is flipped, which maps two's complement order onto unsigned
  // order, so no arithmetic widening is needed.
  function automatic logic out_of_order(
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b,
    input logic             is_signed,
    input int               w,
    input logic             desc
  );
    logic [MAX_W-1:0] flip;
    logic [MAX_W-1:0] ka;
    logic [MAX_W-1:0] kb;
    flip = is_signed ? (MAX_W'(1) << (w - 1)) : '0;
    ka   = a ^ flip;
    kb   = b ^ flip;
    return desc ? (ka < kb) : (ka > kb);
  endfunction

endpackage

// File: rtl/edge_det.sv
// edge_det
// Rising-edge detector for a level command strobe.
//   clk    : clock
//   rstn   : asynchronous active-low reset
//   enable : qualifies the fire output (history is tracked regardless)
//   cmd    : level strobe
//   fire   : 1 in the cycle where cmd rises and enable=1
module edge_det (
  input  logic clk,
  input  logic rstn,
  input  logic enable,
  input  logic cmd,
  output logic fire
);

  logic cmd_q_reg;

  // History is captured every cycle, so a strobe that rises while
  // disabled and is still high after enable returns does not fire.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cmd_q_reg <= 1'b0;
    else       cmd_q_reg <= cmd;
  end

  assign fire = enable & cmd & ~cmd_q_reg;

endmodule

// File: rtl/insertion_sort_p.sv
// insertion_sort_p
// Parametrised insertion-sort buffer with push/pop and in-place sort.
//   clk, rstn          : clock, asynchronous active-low reset
//   enable             : 0 freezes all state
//   clear/push/pop/sort: level strobes, acted on at their rising edge
//   descend            : sort direction, sampled at sort start
//   din / dout         : push data / last popped value
//   full, empty, idle  : status (full when rd+count reaches DEPTH)
//   done               : one-cycle pulse at sort completion
//   err                : sticky illegal-command flag
//   count              : entries held
module insertion_sort_p #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int SIGNED = 0,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic              sort,
  input  logic              descend,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              idle,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  count
);
  import sort_pkg::*;

  localparam int AW = $clog2(DEPTH);
  // Index width one bit wider than the address: holds rd+count and lets
  // j step below rd (MSB set on wrap past zero).
  localparam int IW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_reg, state_next;
  logic [AW-1:0]     rd_reg, rd_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [DATA_W-1:0] dout_reg, dout_next;
  logic              err_reg, err_next;
  logic [IW-1:0]     i_reg, i_next;
  logic [IW-1:0]     j_reg, j_next;
  logic [DATA_W-1:0] key_reg, key_next;
  logic              dir_reg, dir_next;

  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Command edge detection: bit order clear, sort, pop, push.
  logic [3:0] cmd_vec;
  logic [3:0] fire_vec;
  logic       clear_f, sort_f, pop_f, push_f;

  assign cmd_vec = {push, pop, sort, clear};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_edge
      edge_det u_edge (
        .clk    (clk),
        .rstn   (rstn),
        .enable (enable),
        .cmd    (cmd_vec[gi]),
        .fire   (fire_vec[gi])
      );
    end
  endgenerate

  assign clear_f = fire_vec[0];
  assign sort_f  = fire_vec[1];
  assign pop_f   = fire_vec[2];
  assign push_f  = fire_vec[3];

  logic [IW-1:0]     end_addr;
  logic [IW-1:0]     j_inc;
  logic [IW-1:0]     i_inc;
  logic              j_in_range;
  logic              shift;
  logic [DATA_W-1:0] mem_i;
  logic [DATA_W-1:0] mem_j;

  assign end_addr   = IW'(rd_reg) + IW'(count_reg);
  assign j_inc      = j_reg + IW'(1);
  assign i_inc      = i_reg + IW'(1);
  assign j_in_range = !j_reg[AW] && (j_reg[AW-1:0] >= rd_reg);
  assign mem_i      = mem[i_reg[AW-1:0]];
  assign mem_j      = mem[j_reg[AW-1:0]];
  assign shift      = j_in_range &&
                      out_of_order(MAX_W'(mem_j), MAX_W'(key_reg),
                                   SIGNED != 0, DATA_W, dir_reg);

  always_comb begin
    state_next = state_reg;
    rd_next    = rd_reg;
    count_next = count_reg;
    dout_next  = dout_reg;
    err_next   = err_reg;
    i_next     = i_reg;
    j_next     = j_reg;
    key_next   = key_reg;
    dir_next   = dir_reg;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = '0;

    if (enable) begin
      case (state_reg)
        FETCH: begin
          key_next   = mem_i;
          j_next     = i_reg - IW'(1);
          state_next = CMP;
        end
        CMP: begin
          mem_we    = 1'b1;
          mem_waddr = j_inc[AW-1:0];
          if (shift) begin
            mem_wdata = mem_j;
            j_next    = j_reg - IW'(1);
          end else begin
            mem_wdata  = key_reg;
            i_next     = i_inc;
            state_next = (i_inc < end_addr) ? FETCH : DONE;
          end
        end
        DONE:    state_next = IDLE;
        default: ;
      endcase

      // Only the highest-priority fired command acts in a cycle.
      if (clear_f) begin
        state_next = IDLE;
        count_next = '0;
        rd_next    = '0;
        err_next   = 1'b0;
        mem_we     = 1'b0;
      end else if (sort_f) begin
        if (state_reg != IDLE) begin
          err_next = 1'b1;
        end else begin
          i_next     = IW'(rd_reg) + IW'(1);
          dir_next   = descend;
          state_next = (count_reg <= CNT_W'(1)) ? DONE : FETCH;
        end
      end else if (pop_f) begin
        if (state_reg != IDLE || count_reg == '0) begin
          err_next = 1'b1;
        end else begin
          dout_next  = mem[rd_reg];
          count_next = count_reg - CNT_W'(1);
          rd_next    = (count_reg == CNT_W'(1)) ? '0 : rd_reg + AW'(1);
        end
      end else if (push_f) begin
        if (state_reg != IDLE || full) begin
          err_next = 1'b1;
        end else begin
          mem_we     = 1'b1;
          mem_waddr  = end_addr[AW-1:0];
          mem_wdata  = din;
          count_next = count_reg + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      rd_reg    <= '0;
      count_reg <= '0;
      dout_reg  <= '0;
      err_reg   <= 1'b0;
      i_reg     <= '0;
      j_reg     <= '0;
      key_reg   <= '0;
      dir_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      rd_reg    <= rd_next;
      count_reg <= count_next;
      dout_reg  <= dout_next;
      err_reg   <= err_next;
      i_reg     <= i_next;
      j_reg     <= j_next;
      key_reg   <= key_next;
      dir_reg   <= dir_next;
    end
  end

  // Storage carries no reset; reset and clear only move the pointers.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign dout  = dout_reg;
  assign count = count_reg;
  assign err   = err_reg;
  assign empty = (count_reg == '0);
  assign full  = (end_addr == IW'(DEPTH));
  assign idle  = (state_reg == IDLE);
  assign done  = (state_reg == DONE);

endmodule

// File: tb/tb_insertion_sort_p.sv
// Bench for insertion_sort_p: two instances share one stimulus stream,
// u_s (SIGNED=1, DEPTH=8) and u_u (SIGNED=0, DEPTH=4). A queue-level model
// per instance predicts every output, checked on each falling edge.
module tb_insertion_sort_p;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          sort = 1'b0;
  logic          descend = 1'b0;
  logic [DW-1:0] din = '0;

  logic [DW-1:0] dout_s, dout_u;
  logic          full_s, full_u, empty_s, empty_u, idle_s, idle_u;
  logic          done_s, done_u, err_s, err_u;
  logic [3:0]    count_s;
  logic [2:0]    count_u;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  insertion_sort_p #(.DATA_W(DW), .DEPTH(8), .SIGNED(1)) u_s (
    .clk(clk), .rstn(rstn), .enable(enable), .clear(clear), .push(push),
    .pop(pop), .sort(sort), .descend(descend), .din(din), .dout(dout_s),
    .full(full_s), .empty(empty_s), .idle(idle_s), .done(done_s),
    .err(err_s), .count(count_s)
  );

  insertion_sort_p #(.DATA_W(DW), .DEPTH(4), .SIGNED(0)) u_u (
    .clk(clk), .rstn(rstn), .enable(enable), .clear(clear), .push(push),
    .pop(pop), .sort(sort), .descend(descend), .din(din), .dout(dout_u),
    .full(full_u), .empty(empty_u), .idle(idle_u), .done(done_u),
    .err(err_u), .count(count_u)
  );

  // ---------------- reference model (index 0 = u_s, 1 = u_u) ----------
  logic [DW-1:0] m_mem [2][8];
  int            m_rd [2];
  int            m_cnt [2];
  int            m_left [2];   // cycles until back in IDLE; 1 = done cycle
  int            m_depth [2];
  logic          m_err [2];
  logic [DW-1:0] m_dout [2];
  logic          q_clear, q_push, q_pop, q_sort;

  function automatic bit m_ooo(input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input bit desc, input bit sgn);
    if (sgn) return desc ? ($signed(a) < $signed(b)) : ($signed(a) > $signed(b));
    return desc ? (a < b) : (a > b);
  endfunction

  task automatic model_reset();
    q_clear = 0; q_push = 0; q_pop = 0; q_sort = 0;
    for (int k = 0; k < 2; k++) begin
      m_rd[k] = 0; m_cnt[k] = 0; m_left[k] = 0;
      m_err[k] = 0; m_dout[k] = '0;
    end
    m_depth[0] = 8;
    m_depth[1] = 4;
  endtask

  // Sort finishes in 2 cycles per inserted key plus one per inversion,
  // plus the done cycle. The region is sorted immediately in the model.
  task automatic model_sort(input int k, input bit desc);
    int n, base, inv, best;
    logic [DW-1:0] t;
    n = m_cnt[k];
    base = m_rd[k];
    inv = 0;
    for (int a = 0; a < n; a++)
      for (int b = a + 1; b < n; b++)
        if (m_ooo(m_mem[k][base+a], m_mem[k][base+b], desc, k == 0)) inv++;
    for (int a = 0; a < n; a++) begin
      best = a;
      for (int b = a + 1; b < n; b++)
        if (m_ooo(m_mem[k][base+best], m_mem[k][base+b], desc, k == 0)) best = b;
      t = m_mem[k][base+a];
      m_mem[k][base+a] = m_mem[k][base+best];
      m_mem[k][base+best] = t;
    end
    m_left[k] = (n <= 1) ? 1 : 2 * (n - 1) + inv + 1;
  endtask

  task automatic model_step(input int k, input bit fc, input bit fs,
                            input bit fp, input bit fu);
    bit busy;
    busy = (m_left[k] != 0);
    if (busy) m_left[k]--;
    if (fc) begin
      m_cnt[k] = 0; m_rd[k] = 0; m_err[k] = 0; m_left[k] = 0;
    end else if (fs) begin
      if (busy) m_err[k] = 1;
      else model_sort(k, descend);
    end else if (fp) begin
      if (busy || m_cnt[k] == 0) m_err[k] = 1;
      else begin
        m_dout[k] = m_mem[k][m_rd[k]];
        m_rd[k]++;
        m_cnt[k]--;
        if (m_cnt[k] == 0) m_rd[k] = 0;
      end
    end else if (fu) begin
      if (busy || m_rd[k] + m_cnt[k] == m_depth[k]) m_err[k] = 1;
      else begin
        m_mem[k][m_rd[k] + m_cnt[k]] = din;
        m_cnt[k]++;
      end
    end
  endtask

  initial begin
    bit fc, fs, fp, fu;
    model_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) model_reset();
      else begin
        fc = clear && !q_clear && enable;
        fs = sort && !q_sort && enable;
        fp = pop && !q_pop && enable;
        fu = push && !q_push && enable;
        q_clear = clear; q_sort = sort; q_pop = pop; q_push = push;
        if (enable)
          for (int k = 0; k < 2; k++) model_step(k, fc, fs, fp, fu);
      end
    end
  end

  // ---------------- checking ------------------------------------------
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("s.count", count_s, m_cnt[0]);
      chk("s.empty", empty_s, m_cnt[0] == 0);
      chk("s.full",  full_s,  m_rd[0] + m_cnt[0] == m_depth[0]);
      chk("s.idle",  idle_s,  m_left[0] == 0);
      chk("s.done",  done_s,  m_left[0] == 1);
      chk("s.err",   err_s,   m_err[0]);
      chk("s.dout",  dout_s,  m_dout[0]);
      chk("u.count", count_u, m_cnt[1]);
      chk("u.empty", empty_u, m_cnt[1] == 0);
      chk("u.full",  full_u,  m_rd[1] + m_cnt[1] == m_depth[1]);
      chk("u.idle",  idle_u,  m_left[1] == 0);
      chk("u.done",  done_u,  m_left[1] == 1);
      chk("u.err",   err_u,   m_err[1]);
      chk("u.dout",  dout_u,  m_dout[1]);
    end
  end

  // ---------------- stimulus helpers ----------------------------------
  task automatic do_push(input logic [DW-1:0] v);
    din = v; push = 1'b1; @(negedge clk);
    push = 1'b0; @(negedge clk);
  endtask

  task automatic do_pop();
    pop = 1'b1; @(negedge clk);
    pop = 1'b0; @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1; @(negedge clk);
    clear = 1'b0; @(negedge clk);
  endtask

  // Returns at the falling edge right after the sort edge.
  task automatic start_sort(input logic d);
    descend = d; sort = 1'b1; @(negedge clk);
    sort = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 400 && !(idle_s && idle_u); c++) @(negedge clk);
    chk(name, idle_s && idle_u, 1);
  endtask

  // ---------------- directed + random sequence ------------------------
  initial begin
    int lat_s, lat_u;
    bit saw_done;

    @(negedge clk); @(negedge clk);
    chk("rst_idle", idle_s, 1);
    chk("rst_empty", empty_s, 1);
    chk("rst_full", full_u, 0);
    rstn = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    do_clear();

    // 1: basic ascending sort, latency 7
    do_push(16'd3); do_push(16'd1); do_push(16'd2);
    start_sort(1'b0);
    lat_s = 0; lat_u = 0;
    for (int c = 1; c <= 200 && (lat_s == 0 || lat_u == 0); c++) begin
      if (done_s && lat_s == 0) lat_s = c;
      if (done_u && lat_u == 0) lat_u = c;
      @(negedge clk);
    end
    chk("t1_latency_s", lat_s, 7);
    chk("t1_latency_u", lat_u, 7);
    do_pop(); chk("t1_pop0", dout_s, 1); chk("t1_model_pop0", m_dout[0], 1);
    do_pop(); chk("t1_pop1", dout_s, 2);
    do_pop(); chk("t1_pop2", dout_u, 3); chk("t1_empty", empty_s, 1);

    // 2: signed descending / unsigned ascending
    do_clear();
    do_push(16'd5); do_push(16'hFFFF); do_push(16'd0);
    start_sort(1'b1); wait_idle("t2_idle_a");
    do_pop(); chk("t2_s_pop0", dout_s, 5);
    do_pop(); chk("t2_s_pop1", dout_s, 0);
    do_pop(); chk("t2_s_pop2", dout_s, 16'hFFFF);
    do_push(16'd5); do_push(16'hFFFF); do_push(16'd0);
    start_sort(1'b0); wait_idle("t2_idle_b");
    do_pop(); chk("t2_u_pop0", dout_u, 0);
    do_pop(); chk("t2_u_pop1", dout_u, 5);
    do_pop(); chk("t2_u_pop2", dout_u, 65535);

    // 3: full at DEPTH=4, overflow sets err, clear recovers
    do_clear();
    for (int v = 0; v < 4; v++) do_push(DW'(v + 10));
    chk("t3_full", full_u, 1);
    do_push(16'd99);
    chk("t3_err", err_u, 1); chk("t3_count", count_u, 4);
    do_clear();
    chk("t3_clr_err", err_u, 0); chk("t3_clr_empty", empty_u, 1);

    // 4: sort covers only the live window
    do_push(16'd9); do_push(16'd7);
    do_pop(); chk("t4_pop9", dout_s, 9);
    do_push(16'd8); do_push(16'd6);
    start_sort(1'b0); wait_idle("t4_idle");
    do_pop(); chk("t4_pop0", dout_s, 6);
    do_pop(); chk("t4_pop1", dout_u, 7);
    do_pop(); chk("t4_pop2", dout_s, 8);

    // 5: duplicates, push during sort is illegal
    do_clear();
    do_push(16'h0102); do_push(16'h0102); do_push(16'h0001);
    start_sort(1'b0);
    do_push(16'h0055);
    chk("t5_err", err_s, 1); chk("t5_count", count_s, 3);
    wait_idle("t5_idle");
    do_pop(); chk("t5_pop0", dout_s, 16'h0001);
    do_pop(); chk("t5_pop1", dout_s, 16'h0102);

    // 6: freeze mid-sort, then abort with clear
    do_clear();
    for (int v = 8; v >= 1; v--) do_push(DW'(v));
    start_sort(1'b0);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_frozen_busy", idle_s, 0);
    enable = 1'b1;
    repeat (2) @(negedge clk);
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    chk("t6_clr_idle", idle_s, 1); chk("t6_clr_count", count_s, 0);
    saw_done = 0;
    for (int c = 0; c < 40; c++) begin
      if (done_s) saw_done = 1;
      @(negedge clk);
    end
    chk("t6_no_done", saw_done, 0);

    // random traffic, with one asynchronous reset in the middle
    for (int c = 0; c < 2000; c++) begin
      enable  = ($urandom_range(9) != 0);
      clear   = ($urandom_range(59) == 0);
      push    = ($urandom_range(2) == 0);
      pop     = ($urandom_range(3) == 0);
      sort    = ($urandom_range(11) == 0);
      descend = $urandom_range(1);
      din     = $urandom_range(1) ? DW'($urandom_range(7)) : DW'($urandom);
      if (c == 1000) begin
        #2 rstn = 1'b0;
        @(negedge clk);
        #2 rstn = 1'b1;
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
